mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 188 ++++++++++++++++++
 tb/tb_mdu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit with HI/LO and a fixed-latency busy window.
// Define MDU_MADD_EN to add madd/maddu (ops 9, 10) accumulating into HI/LO.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  localparam logic [4:0] MUL_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
`ifdef MDU_MADD_EN
  logic        pend_acc_q, pend_acc_d;
  logic [63:0] acc_sum;
`endif

  logic        is_mul, is_mulu, is_div, is_divu, is_acc;
  logic        op_mul, op_div, last;
  logic [63:0] ma, mb, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    is_mul  = 1'b0;
    is_mulu = 1'b0;
    is_div  = 1'b0;
    is_divu = 1'b0;
    is_acc  = 1'b0;
    case (MDUOp)
      OP_MULT:  is_mul  = 1'b1;
      OP_MULTU: is_mulu = 1'b1;
      OP_DIV:   is_div  = 1'b1;
      OP_DIVU:  is_divu = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul  = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mulu = 1'b1; is_acc = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign op_mul = is_mul | is_mulu;
  assign op_div = is_div | is_divu;

  // 64-bit product of extended operands is exact mod 2^64 for both signednesses
  assign ma   = is_mul ? {{32{A[31]}}, A} : {32'b0, A};
  assign mb   = is_mul ? {{32{B[31]}}, B} : {32'b0, B};
  assign prod = ma * mb;

  // Magnitude division keeps the 0x80000000 / -1 case a clean wrap
  assign a_neg = is_div & A[31];
  assign b_neg = is_div & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign last = (cnt_q <= 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
`ifdef MDU_MADD_EN
      pend_acc_q <= pend_acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_mul | op_div) state_d = S_BUSY;
      S_BUSY:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MDU_MADD_EN
  assign acc_sum = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
`endif

  always_comb begin
    Busy      = (state_q == S_BUSY);
    Start     = (op_mul | op_div) & ~Busy;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
`ifdef MDU_MADD_EN
    pend_acc_d = pend_acc_q;
`endif
    if (Busy) begin
      cnt_d = cnt_q - 5'd1;
      if (last && pend_wr_q) begin
`ifdef MDU_MADD_EN
        if (pend_acc_q) begin
          hi_d = acc_sum[63:32];
          lo_d = acc_sum[31:0];
        end else begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
`else
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
`endif
      end
    end else if (Start) begin
      cnt_d     = op_mul ? MUL_N : DIV_N;
      pend_hi_d = op_mul ? prod[63:32] : rem;
      pend_lo_d = op_mul ? prod[31:0] : quo;
      pend_wr_d = op_mul | (B != 32'd0);
`ifdef MDU_MADD_EN
      pend_acc_d = is_acc;
`endif
    end else if (MDUOp == OP_MTHI) begin
      hi_d = A;
    end else if (MDUOp == OP_MTLO) begin
      lo_d = A;
    end
  end

  always_comb begin
    Out = 32'd0;
    case (MDUOp)
      OP_MFHI: Out = hi_q;
      OP_MFLO: Out = lo_q;
      default: ;
    endcase
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency, results, hazards and reset abort.
// Build with MDU_MADD_EN defined to exercise madd instead of the op-9 no-op.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HI, LO, Out;

  int n_chk  = 0;
  int n_fail = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input string tag);
    MDUOp = op; A = a; B = b;
    #1;
    check({tag, "_start"}, 32'(Start), 32'd1);
    step();
    MDUOp = 4'd0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      step();
    end
    check({tag, "_done"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", 32'(Start), 32'd0);
    check("rst_out", Out, 32'd0);

    issue(4'd1, 32'hFFFFFFFE, 32'd3, 5, "mult");
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "multu");
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div");
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd0, 10, "divu0");
    check("divu0_hi", HI, 32'hFFFFFFFF);
    check("divu0_lo", LO, 32'hFFFFFFFD);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "divovf");
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'd0);

    issue(4'd3, 32'd7, 32'hFFFFFFFE, 10, "divneg");
    check("divneg_lo", LO, 32'hFFFFFFFD);
    check("divneg_hi", HI, 32'd1);

    issue(4'd4, 32'd100, 32'd7, 10, "divu");
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    MDUOp = 4'd7; A = 32'h12345678;
    step();
    MDUOp = 4'd8; A = 32'hCAFEF00D;
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", 32'(Busy), 32'd0);
    step();
    MDUOp = 4'd6;
    #1;
    check("mtlo_lo", LO, 32'hCAFEF00D);
    check("mflo_out", Out, 32'hCAFEF00D);
    MDUOp = 4'd5;
    #1;
    check("mfhi_out", Out, 32'h12345678);

    // mult with mf*/mt*/new ops presented during the busy window
    MDUOp = 4'd1; A = 32'd2; B = 32'd3;
    step();
    MDUOp = 4'd5;
    #1;
    check("hz_out_old", Out, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      check("hz_busy", 32'(Busy), 32'd1);
      check("hz_hold", HI, 32'h12345678);
      if (i == 1) begin
        MDUOp = 4'd1; A = 32'd9; B = 32'd9;
        #1;
        check("hz_start", 32'(Start), 32'd0);
      end else begin
        MDUOp = 4'd7; A = 32'hDEADBEEF;
      end
      step();
    end
    MDUOp = 4'd0;
    check("hz_done", 32'(Busy), 32'd0);
    check("hz_hi", HI, 32'd0);
    check("hz_lo", LO, 32'd6);

    MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    step();
    MDUOp = 4'd0;
    for (int i = 0; i < 3; i++) step();
    check("ab_busy4", 32'(Busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ab_busy", 32'(Busy), 32'd0);
    check("ab_hi", HI, 32'd0);
    check("ab_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("ab_late_hi", HI, 32'd0);
    check("ab_late_lo", LO, 32'd0);
    check("ab_late_busy", 32'(Busy), 32'd0);

`ifdef MDU_MADD_EN
    MDUOp = 4'd7; A = 32'd0;
    step();
    MDUOp = 4'd8; A = 32'hFFFFFFFF;
    step();
    issue(4'd9, 32'd1, 32'd1, 5, "madd");
    check("madd_hi", HI, 32'd1);
    check("madd_lo", LO, 32'd0);
`else
    MDUOp = 4'd9; A = 32'd1; B = 32'd1;
    #1;
    check("op9_start", 32'(Start), 32'd0);
    step();
    check("op9_busy", 32'(Busy), 32'd0);
    check("op9_lo", LO, 32'd0);
    MDUOp = 4'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
